irq_sequencer: RTL

IRQ_SEQUENCER -- requirements
Module: irq_sequencer

---
 rtl/irq_ctrl_pkg.sv | 13 +
 rtl/irq_priority_chain.sv | 22 ++
 rtl/irq_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and FSM state type for the interrupt sequencer.
package irq_ctrl_pkg;

    localparam int unsigned IRQ_NUM = 16;
    localparam logic [11:0] MCAUSE_IRQ_PREFIX = 12'h800;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_priority_chain.sv
// Fixed-priority arbiter: lowest set index of eligible wins, one-hot output.
module irq_priority_chain
    import irq_ctrl_pkg::*;
(
    input  logic [IRQ_NUM-1:0] eligible,
    output logic [IRQ_NUM-1:0] winner
);

    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < IRQ_NUM; k++) begin
            if (eligible[k] && !found) begin
                winner[k] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Edge-triggered interrupt sequencer: latches rises into pending, presents one
// request at a time to the core and signals end-of-service back to the device.
module irq_sequencer
    import irq_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    input  logic [IRQ_NUM-1:0] mie_i,
    input  logic               mstatus_mie_i,
    input  logic               irq_ack_i,
    input  logic               mret_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic [IRQ_NUM-1:0] irq_ret_o,
    output logic [IRQ_NUM-1:0] pending_o
);

    irq_state_e         state_q, state_d;
    logic [IRQ_NUM-1:0] prev_q;
    logic               armed_q;
    logic [IRQ_NUM-1:0] pending_q, pending_d;
    logic [IRQ_NUM-1:0] sel_q, sel_d;
    logic [IRQ_NUM-1:0] rise, eligible, winner, clr;
    logic [IRQ_NUM-1:0] ret_d;
    logic               irq_d;
    logic [31:0]        cause_d;

    irq_priority_chain u_chain (
        .eligible (eligible),
        .winner   (winner)
    );

    // armed_q suppresses rise detection on the first edge after reset release
    always_comb begin
        rise      = armed_q ? (irq_req_i & ~prev_q) : '0;
        eligible  = mstatus_mie_i ? (pending_q & mie_i) : '0;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        clr     = '0;
        ret_d   = '0;
        irq_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                    sel_d   = winner;
                end
            end
            REQ: begin
                if (irq_ack_i) begin
                    state_d = SERVICE;
                end else if (!mstatus_mie_i || !(|(mie_i & sel_q))) begin
                    state_d = IDLE;
                end else begin
                    irq_d = 1'b1;
                end
            end
            SERVICE: begin
                if (mret_i) begin
                    ret_d   = sel_q;
                    clr     = sel_q;
                    sel_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // set wins over clear on the same line
        pending_d = (pending_q & ~clr) | rise;
        cause_d   = irq_d ? {MCAUSE_IRQ_PREFIX, sel_q, 4'b0000} : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            armed_q     <= 1'b0;
            pending_q   <= '0;
            sel_q       <= '0;
            irq_o       <= 1'b0;
            irq_cause_o <= '0;
            irq_ret_o   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= irq_req_i;
            armed_q     <= 1'b1;
            pending_q   <= pending_d;
            sel_q       <= sel_d;
            irq_o       <= irq_d;
            irq_cause_o <= cause_d;
            irq_ret_o   <= ret_d;
        end
    end

    assign pending_o = pending_q;

endmodule
